// File: rtl/ld_st_queue.sv
// In-order load/store queue: buffers DEPTH memory ops and serialises them onto a single-port memory handshake.
// Optional macro LSU_ALIGN_TRAP_EN: misaligned ops fault without touching memory.
module ld_st_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 64,
   parameter int TAG_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iss_valid,
   output logic              iss_ready,
   input  logic              iss_store,
   input  logic [1:0]        iss_size,
   input  logic              iss_signed,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic [63:0]       iss_wdata,
   input  logic [TAG_W-1:0]  iss_tag,
   input  logic              flush,
   output logic [ADDR_W-1:0] mem_address,
   output logic [1:0]        mem_datasize,
   output logic              mem_read,
   output logic              mem_write,
   output logic [63:0]       mem_writedata,
   input  logic [63:0]       mem_readdata,
   input  logic              mem_done,
   output logic              cmp_valid,
   input  logic              cmp_ready,
   output logic [TAG_W-1:0]  cmp_tag,
   output logic [63:0]       cmp_data,
   output logic              cmp_ovf,
   output logic              cmp_fault
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic              store;
      logic [1:0]        size;
      logic              sgn;
      logic [ADDR_W-1:0] addr;
      logic [63:0]       wdata;
      logic [TAG_W-1:0]  tag;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

   function automatic logic [63:0] trunc64(input logic [63:0] w, input logic [1:0] sz);
      case (sz)
         2'd0:    return {56'd0, w[7:0]};
         2'd1:    return {48'd0, w[15:0]};
         2'd2:    return {32'd0, w[31:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [63:0] extend64(input logic [63:0] d, input logic [1:0] sz, input logic sgn);
      case (sz)
         2'd0:    return {{56{sgn & d[7]}},  d[7:0]};
         2'd1:    return {{48{sgn & d[15]}}, d[15:0]};
         2'd2:    return {{32{sgn & d[31]}}, d[31:0]};
         default: return d;
      endcase
   endfunction

   // Overflow when the discarded upper bits plus the new sign bit are not all equal.
   function automatic logic store_ovf(input logic [63:0] w, input logic [1:0] sz);
      case (sz)
         2'd0:    return !((&w[63:7])  || !(|w[63:7]));
         2'd1:    return !((&w[63:15]) || !(|w[63:15]));
         2'd2:    return !((&w[63:31]) || !(|w[63:31]));
         default: return 1'b0;
      endcase
   endfunction

   entry_t            q [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   state_t            state;
   entry_t            head;
   logic [ADDR_W-1:0] size_mask;
   logic              head_fault;
   logic              do_push, do_pop, start_ok;
   logic              drop_q;
   logic              cur_store, cur_sgn, cur_ovf;
   logic [1:0]        cur_size;
   logic [TAG_W-1:0]  cur_tag;

   assign head      = q[rd_ptr];
   assign size_mask = {ADDR_W{1'b1}} << head.size;
   assign iss_ready = !reset && (count < CW'(DEPTH));
   assign do_push   = iss_valid && iss_ready && !flush;
   assign start_ok  = (count != '0) && !flush;

`ifdef LSU_ALIGN_TRAP_EN
   logic fault_q;
   assign head_fault = |(head.addr & ~size_mask);
   assign cmp_fault  = fault_q;
`else
   assign head_fault = 1'b0;
   assign cmp_fault  = 1'b0;
`endif

   // The op on memory stays at the head until mem_done, so its slot is freed only then.
   assign do_pop = !flush &&
                   ((state == S_MEM && mem_done && !drop_q) ||
                    (state == S_IDLE && start_ok && head_fault));

   always_ff @(posedge clk) begin
      if (do_push)
         q[wr_ptr] <= '{store: iss_store, size: iss_size, sgn: iss_signed,
                        addr: iss_addr, wdata: iss_wdata, tag: iss_tag};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         mem_address   <= '0;
         mem_datasize  <= '0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_writedata <= '0;
         cmp_valid     <= 1'b0;
         cmp_tag       <= '0;
         cmp_data      <= '0;
         cmp_ovf       <= 1'b0;
         drop_q        <= 1'b0;
         cur_store     <= 1'b0;
         cur_sgn       <= 1'b0;
         cur_ovf       <= 1'b0;
         cur_size      <= '0;
         cur_tag       <= '0;
`ifdef LSU_ALIGN_TRAP_EN
         fault_q       <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok && !head_fault) begin
                  mem_address   <= head.addr & size_mask;
                  mem_datasize  <= head.size;
                  mem_read      <= !head.store;
                  mem_write     <= head.store;
                  mem_writedata <= trunc64(head.wdata, head.size);
                  cur_store     <= head.store;
                  cur_sgn       <= head.sgn;
                  cur_ovf       <= head.sgn && store_ovf(head.wdata, head.size);
                  cur_size      <= head.size;
                  cur_tag       <= head.tag;
                  state         <= S_MEM;
               end
`ifdef LSU_ALIGN_TRAP_EN
               else if (start_ok) begin
                  cmp_valid <= 1'b1;
                  cmp_tag   <= head.tag;
                  cmp_data  <= '0;
                  cmp_ovf   <= 1'b0;
                  fault_q   <= 1'b1;
                  state     <= S_RESP;
               end
`endif
            end
            S_MEM: begin
               if (mem_done) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  drop_q    <= 1'b0;
                  if (drop_q || flush) begin
                     state <= S_IDLE;
                  end else begin
                     cmp_valid <= 1'b1;
                     cmp_tag   <= cur_tag;
                     cmp_data  <= cur_store ? 64'd0 : extend64(mem_readdata, cur_size, cur_sgn);
                     cmp_ovf   <= cur_store && cur_ovf;
`ifdef LSU_ALIGN_TRAP_EN
                     fault_q   <= 1'b0;
`endif
                     state     <= S_RESP;
                  end
               end else if (flush) begin
                  drop_q <= 1'b1;
               end
            end
            S_RESP: begin
               if (cmp_ready) begin
                  cmp_valid <= 1'b0;
                  if (start_ok && !head_fault) begin
                     mem_address   <= head.addr & size_mask;
                     mem_datasize  <= head.size;
                     mem_read      <= !head.store;
                     mem_write     <= head.store;
                     mem_writedata <= trunc64(head.wdata, head.size);
                     cur_store     <= head.store;
                     cur_sgn       <= head.sgn;
                     cur_ovf       <= head.sgn && store_ovf(head.wdata, head.size);
                     cur_size      <= head.size;
                     cur_tag       <= head.tag;
                     state         <= S_MEM;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
